// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal parameter ranges and
// the parity helper that the future transmitter will reuse.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  // Expected parity bit for a word; shorter words are zero-extended by the caller.
  function automatic logic uart_parity(input logic [DATA_BITS_MAX-1:0] word,
                                       input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks, restartable
// via clr so the receiver can phase-align to a detected start edge.
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // A divide-by-one still needs a one-bit counter that simply stays at zero.
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with false-start rejection, 1/2 stop bits and
// break handling. Optional parity bit enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// RX_IDLE   | line idle, watching for a 1->0 edge on rxs
// RX_START  | waiting for mid-start sample; a 1 there is a false start
// RX_DATA   | sampling DATA_BITS data bits, LSB first
// RX_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// RX_STOP   | sampling stop bits; the strobe cycle also lives here
// RX_BREAK  | line stuck low after a frame, waiting for it to return high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  uart_rx_state_t state, state_nxt;

  logic                 sync_1, rxs, rxs_d;
  logic                 fall, clr, tick, sample, last_stop;
  logic [TC_W-1:0]      tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shadow;
  logic                 fe_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
    end else begin
      sync_1 <= rx_data;
      rxs    <= sync_1;
      rxs_d  <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Counter free-runs once aligned; every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == TC_LAST) ? '0 : tick_cnt + TC_W'(1);
    end
  end

  assign sample    = tick && (tick_cnt == TC_MID);
  assign last_stop = (state == RX_STOP) && sample && !valid && (bit_cnt == STOP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          state_nxt = RX_START;
          clr       = 1'b1;
        end
      end
      RX_START: begin
        if (sample) state_nxt = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (sample && (bit_cnt == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = RX_PARITY;
`else
          state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (sample) state_nxt = RX_STOP;
      end
`endif
      RX_STOP: begin
        // valid marks the strobe cycle; a new start edge here must not be lost.
        if (valid) begin
          if (fall) begin
            state_nxt = RX_START;
            clr       = 1'b1;
          end else begin
            state_nxt = rxs ? RX_IDLE : RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rxs) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign busy = (state != RX_IDLE);

`ifdef UART_RX_PARITY_EN
  logic pe_sh;
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pe_sh <= 1'b0;
    end else if ((state == RX_PARITY) && sample) begin
      pe_sh <= (rxs != uart_parity(DATA_BITS_MAX'(shadow), (PARITY_ODD != 0)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (last_stop) begin
      parity_q <= pe_sh;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shadow    <= '0;
      fe_sh     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        bit_cnt <= '0;
        fe_sh   <= 1'b0;
      end else if ((state == RX_DATA) && sample) begin
        shadow  <= {rxs, shadow[DATA_BITS-1:1]};
        bit_cnt <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
      end else if ((state == RX_STOP) && sample && !valid) begin
        if (!rxs) fe_sh <= 1'b1;
        if (last_stop) begin
          valid     <= 1'b1;
          data      <= shadow;
          frame_err <= fe_sh | ~rxs;
          bit_cnt   <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8-bit odd-parity-capable receiver and a
// 9-bit two-stop receiver, with expected words queued as frames are driven.
module tb_uart_rx_os;

  localparam int BC = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic [7:0] data0;
  logic [8:0] data1;
  logic       valid0, fe0, pe0, busy0;
  logic       valid1, fe1, pe1, busy1;

  int   checks = 0;
  int   errors = 0;
  int   vcnt0 = 0, vcnt1 = 0;
  int   tot0 = 0, tot1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .BAUD_DIV(1), .OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx0), .data(data0), .valid(valid0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0)
  );

  uart_rx_os #(
    .BAUD_DIV(1), .OVERSAMPLE(16), .DATA_BITS(9), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut9 (
    .clk(clk), .rst(rst), .rx_data(rx1), .data(data1), .valid(valid1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pbit_of(input logic [8:0] d, input int n, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < n; i++) p = p ^ d[i];
    return p;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (valid0) begin
      vcnt0++;
      if (q0.size() == 0) begin
        chk("unexpected_valid0", 16'(valid0), 16'h0);
      end else begin
        e = q0.pop_front();
        chk("data0", 16'(data0), 16'(e.d[7:0]));
        chk("frame_err0", 16'(fe0), 16'(e.fe));
        chk("parity_err0", 16'(pe0), 16'(e.pe));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (valid1) begin
      vcnt1++;
      if (q1.size() == 0) begin
        chk("unexpected_valid1", 16'(valid1), 16'h0);
      end else begin
        e = q1.pop_front();
        chk("data1", 16'(data1), 16'(e.d));
        chk("frame_err1", 16'(fe1), 16'(e.fe));
        chk("parity_err1", 16'(pe1), 16'(e.pe));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic v);
    if (lane == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic expect_frame(input int lane, input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    if (lane == 0) begin
      q0.push_back(e);
      tot0++;
    end else begin
      q1.push_back(e);
      tot1++;
    end
  endtask

  // Leaves the line at the last stop-bit value so callers can hold a break.
  task automatic send(input int lane, input logic [8:0] d, input int nbits,
                      input logic pbit, input logic [1:0] stop_vals, input int nstop,
                      input int rst_bit);
    drive(lane, 1'b0);
    wait_clks(BC);
    for (int k = 0; k < nbits; k++) begin
      drive(lane, d[k]);
      if (k == rst_bit) begin
        wait_clks(8);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 16'(valid0), 16'h0);
        chk("rst_data0", 16'(data0), 16'h0);
        chk("rst_fe0", 16'(fe0), 16'h0);
        chk("rst_pe0", 16'(pe0), 16'h0);
        chk("rst_busy0", 16'(busy0), 16'h0);
        chk("rst_data1", 16'(data1), 16'h0);
        wait_clks(BC - 9);
      end else begin
        wait_clks(BC);
      end
    end
    if (NPAR != 0) begin
      drive(lane, pbit);
      wait_clks(BC);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(lane, stop_vals[s]);
      wait_clks(BC);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q0", 16'(q0.size()), 16'h0);
    chk("drain_q1", 16'(q1.size()), 16'h0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid0", 16'(valid0), 16'h0);
    chk("reset_busy0", 16'(busy0), 16'h0);
    chk("reset_data0", 16'(data0), 16'h0);
    chk("reset_fe0", 16'(fe0), 16'h0);
    chk("reset_pe0", 16'(pe0), 16'h0);
    chk("reset_data1", 16'(data1), 16'h0);
    wait_clks(10);

    // back-to-back frames
    expect_frame(0, 9'h055, 1'b0, 1'b0);
    expect_frame(0, 9'h0A3, 1'b0, 1'b0);
    send(0, 9'h055, 8, pbit_of(9'h055, 8, 1'b1), 2'b01, 1, -1);
    send(0, 9'h0A3, 8, pbit_of(9'h0A3, 8, 1'b1), 2'b01, 1, -1);
    wait_drain(200);
    chk("b2b_count", 16'(vcnt0), 16'd2);

    // false start: 4 clocks low
    wait_clks(BC);
    base = vcnt0;
    drive(0, 1'b0);
    wait_clks(4);
    drive(0, 1'b1);
    wait_clks(6);
    @(negedge clk);
    chk("fs_busy_before_sample", 16'(busy0), 16'h1);
    wait_clks(1);
    @(negedge clk);
    chk("fs_busy_after_sample", 16'(busy0), 16'h0);
    wait_clks(2 * BC);
    chk("fs_no_valid", 16'(vcnt0), 16'(base));

    // stop bit 0 then break
    base = vcnt0;
    expect_frame(0, 9'h03C, 1'b1, 1'b0);
    send(0, 9'h03C, 8, pbit_of(9'h03C, 8, 1'b1), 2'b00, 1, -1);
    wait_clks(40 * BC);
    chk("break_one_valid", 16'(vcnt0), 16'(base + 1));
    chk("break_busy", 16'(busy0), 16'h1);
    drive(0, 1'b1);
    wait_clks(BC);
    chk("break_exit_busy", 16'(busy0), 16'h0);
    chk("break_no_extra", 16'(vcnt0), 16'(base + 1));
    expect_frame(0, 9'h001, 1'b0, 1'b0);
    send(0, 9'h001, 8, pbit_of(9'h001, 8, 1'b1), 2'b01, 1, -1);
    wait_drain(200);

`ifdef UART_RX_PARITY_EN
    expect_frame(0, 9'h007, 1'b0, 1'b0);
    send(0, 9'h007, 8, 1'b0, 2'b01, 1, -1);
    expect_frame(0, 9'h007, 1'b0, 1'b1);
    send(0, 9'h007, 8, 1'b1, 2'b01, 1, -1);
    wait_drain(200);
`endif

    // 9-bit, two stop bits
    expect_frame(1, 9'h1FF, 1'b0, 1'b0);
    send(1, 9'h1FF, 9, pbit_of(9'h1FF, 9, 1'b0), 2'b11, 2, -1);
    expect_frame(1, 9'h1FF, 1'b1, 1'b0);
    send(1, 9'h1FF, 9, pbit_of(9'h1FF, 9, 1'b0), 2'b01, 2, -1);
    drive(1, 1'b1);
    wait_drain(200);
    wait_clks(BC);
    chk("nine_idle_busy", 16'(busy1), 16'h0);

    // reset during data bit 4 of 0xF0; remaining bits carry no falling edge
    wait_clks(BC);
    base = vcnt0;
    send(0, 9'h0F0, 8, pbit_of(9'h0F0, 8, 1'b1), 2'b01, 1, 4);
    wait_clks(2 * BC);
    chk("rst_no_strobe", 16'(vcnt0), 16'(base));
    expect_frame(0, 9'h05A, 1'b0, 1'b0);
    send(0, 9'h05A, 8, pbit_of(9'h05A, 8, 1'b1), 2'b01, 1, -1);
    wait_drain(200);

    chk("total_valid0", 16'(vcnt0), 16'(tot0));
    chk("total_valid1", 16'(vcnt1), 16'(tot1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
